// File: rtl/var_lane_fifo_pkg.sv
// Shared defaults and modular index helpers for the variable-lane FIFO.
package var_lane_fifo_pkg;

  localparam int DefElemWidth = 8;
  localparam int DefNumLanes  = 4;
  localparam int DefFifoDepth = 16;

  // Single-subtraction wrap; callers guarantee a < mod and b <= mod.
  function automatic int wrap_add(int a, int b, int mod);
    int s;
    s = a + b;
    return (s >= mod) ? s - mod : s;
  endfunction

  function automatic int lane_idx(int start, int k, int lanes);
    return wrap_add(start, k, lanes);
  endfunction

endpackage

// File: rtl/var_lane_fifo_if.sv
// Producer/consumer handshake bundle for var_lane_fifo; slave = FIFO side.
interface var_lane_fifo_if import var_lane_fifo_pkg::*; #(
  parameter int ElemWidth = DefElemWidth,
  parameter int NumLanes  = DefNumLanes,
  parameter int FifoDepth = DefFifoDepth
);
  localparam int LaneW = (NumLanes > 1) ? $clog2(NumLanes) : 1;
  localparam int NumW  = $clog2(NumLanes + 1);

  logic [NumW-1:0]               in_num_lanes_i;
  logic [LaneW-1:0]              in_start_lane_i;
  logic                          in_req_valid_o;
  logic [NumLanes*ElemWidth-1:0] in_data_i;
  logic                          in_valid_i;
  logic                          in_ready_o;
  logic [NumW-1:0]               out_num_lanes_i;
  logic [LaneW-1:0]              out_start_lane_i;
  logic                          out_req_valid_o;
  logic [NumLanes*ElemWidth-1:0] out_data_o;
  logic                          out_valid_o;
  logic                          out_ready_i;

  modport slave (
    input  in_num_lanes_i, in_start_lane_i, in_data_i, in_valid_i,
    input  out_num_lanes_i, out_start_lane_i, out_ready_i,
    output in_req_valid_o, in_ready_o, out_req_valid_o, out_data_o, out_valid_o
  );

  modport master (
    output in_num_lanes_i, in_start_lane_i, in_data_i, in_valid_i,
    output out_num_lanes_i, out_start_lane_i, out_ready_i,
    input  in_req_valid_o, in_ready_o, out_req_valid_o, out_data_o, out_valid_o
  );

endinterface

// File: rtl/var_lane_rotate.sv
// Lane barrel rotator: gather (lane start+k -> slot k) or scatter (slot k -> lane start+k),
// zeroing every slot/lane whose element index is >= count_i.
module var_lane_rotate import var_lane_fifo_pkg::*; #(
  parameter int ElemWidth = DefElemWidth,
  parameter int NumLanes  = DefNumLanes,
  parameter bit Scatter   = 1'b0,
  localparam int LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1,
  localparam int NumW     = $clog2(NumLanes + 1)
) (
  input  logic [NumLanes*ElemWidth-1:0] data_i,
  input  logic [LaneW-1:0]              start_i,
  input  logic [NumW-1:0]               count_i,
  output logic [NumLanes*ElemWidth-1:0] data_o
);

  logic [ElemWidth-1:0] lane_in  [NumLanes];
  logic [ElemWidth-1:0] lane_out [NumLanes];

  always_comb begin
    for (int k = 0; k < NumLanes; k++) begin
      lane_in[k]  = data_i[k*ElemWidth +: ElemWidth];
      lane_out[k] = '0;
    end
    for (int k = 0; k < NumLanes; k++) begin
      if (k < int'(count_i)) begin
        if (Scatter) lane_out[LaneW'(lane_idx(int'(start_i), k, NumLanes))] = lane_in[k];
        else         lane_out[k] = lane_in[LaneW'(lane_idx(int'(start_i), k, NumLanes))];
      end
    end
    data_o = '0;
    for (int k = 0; k < NumLanes; k++) data_o[k*ElemWidth +: ElemWidth] = lane_out[k];
  end

endmodule

// File: rtl/var_lane_fifo.sv
// Lane-granular FWFT FIFO with wrap-around lane windows, any depth >= NumLanes and flush.
// Define VAR_LANE_FIFO_WATERMARK_EN to add the max_level_o peak-occupancy output.
module var_lane_fifo import var_lane_fifo_pkg::*; #(
  parameter int ElemWidth      = DefElemWidth,
  parameter int NumLanes       = DefNumLanes,
  parameter int FifoDepth      = DefFifoDepth,
  parameter int AlmostFullThr  = FifoDepth - NumLanes,
  parameter int AlmostEmptyThr = NumLanes,
  localparam int CntW          = $clog2(FifoDepth + 1),
  localparam int PtrW          = (FifoDepth > 1) ? $clog2(FifoDepth) : 1,
  localparam int NumW          = $clog2(NumLanes + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  var_lane_fifo_if.slave  bus,
  output logic [CntW-1:0] space_available_o,
  output logic [CntW-1:0] elem_available_o,
  output logic            almost_full_o,
  output logic            almost_empty_o
`ifdef VAR_LANE_FIFO_WATERMARK_EN
  ,
  output logic [CntW-1:0] max_level_o
`endif
);

  logic [PtrW-1:0]               rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]               count_q, count_d;
  logic [ElemWidth-1:0]          mem_q [FifoDepth];
  logic [ElemWidth-1:0]          mem_d [FifoDepth];
  logic [NumLanes*ElemWidth-1:0] in_elems, rd_elems;
  logic [NumW-1:0]               pop_cnt;
  logic                          push_fire, pop_fire;
  int                            push_n, pop_n;

  // Ready/valid look only at the registered count, never at in_valid_i/out_ready_i.
  assign bus.in_req_valid_o  = (bus.in_num_lanes_i != '0) && (int'(bus.in_num_lanes_i) <= NumLanes);
  assign bus.out_req_valid_o = (bus.out_num_lanes_i != '0) && (int'(bus.out_num_lanes_i) <= NumLanes);
  assign bus.in_ready_o  = bus.in_req_valid_o &&
                           ((FifoDepth - int'(count_q)) >= int'(bus.in_num_lanes_i));
  assign bus.out_valid_o = bus.out_req_valid_o && (int'(count_q) >= int'(bus.out_num_lanes_i));

  assign push_fire = bus.in_valid_i && bus.in_ready_o;
  assign pop_fire  = bus.out_valid_o && bus.out_ready_i;
  assign push_n    = push_fire ? int'(bus.in_num_lanes_i) : 0;
  assign pop_n     = pop_fire ? int'(bus.out_num_lanes_i) : 0;
  assign pop_cnt   = bus.out_valid_o ? bus.out_num_lanes_i : '0;

  assign space_available_o = CntW'(FifoDepth - int'(count_q));
  assign elem_available_o  = count_q;
  assign almost_full_o     = int'(count_q) >= AlmostFullThr;
  assign almost_empty_o    = int'(count_q) <= AlmostEmptyThr;

  var_lane_rotate #(.ElemWidth(ElemWidth), .NumLanes(NumLanes), .Scatter(1'b0)) u_gather (
    .data_i (bus.in_data_i),
    .start_i(bus.in_start_lane_i),
    .count_i(bus.in_num_lanes_i),
    .data_o (in_elems)
  );

  var_lane_rotate #(.ElemWidth(ElemWidth), .NumLanes(NumLanes), .Scatter(1'b1)) u_scatter (
    .data_i (rd_elems),
    .start_i(bus.out_start_lane_i),
    .count_i(pop_cnt),
    .data_o (bus.out_data_o)
  );

  // The NumLanes oldest slots, oldest in slot 0; slots beyond count are masked by the scatter.
  always_comb begin
    rd_elems = '0;
    for (int k = 0; k < NumLanes; k++)
      rd_elems[k*ElemWidth +: ElemWidth] = mem_q[PtrW'(wrap_add(int'(rd_ptr_q), k, FifoDepth))];
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      for (int k = 0; k < NumLanes; k++)
        if (k < push_n)
          mem_d[PtrW'(wrap_add(int'(wr_ptr_q), k, FifoDepth))] = in_elems[k*ElemWidth +: ElemWidth];
      wr_ptr_d = PtrW'(wrap_add(int'(wr_ptr_q), push_n, FifoDepth));
      rd_ptr_d = PtrW'(wrap_add(int'(rd_ptr_q), pop_n, FifoDepth));
      count_d  = CntW'(int'(count_q) + push_n - pop_n);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) mem_q <= mem_d;

`ifdef VAR_LANE_FIFO_WATERMARK_EN
  logic [CntW-1:0] max_level_q, max_level_d;

  always_comb begin
    max_level_d = max_level_q;
    if (flush_i)                   max_level_d = '0;
    else if (count_d > max_level_q) max_level_d = count_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) max_level_q <= '0;
    else       max_level_q <= max_level_d;
  end

  assign max_level_o = max_level_q;
`endif

endmodule

// File: tb/tb_var_lane_fifo.sv
// Self-checking bench for var_lane_fifo (ElemWidth=4, NumLanes=4, FifoDepth=8) against a queue model.
module tb_var_lane_fifo;

  localparam int EW = 4;
  localparam int NL = 4;
  localparam int FD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [3:0] space, elem;
  logic af, ae;
`ifdef VAR_LANE_FIFO_WATERMARK_EN
  logic [3:0] maxl;
`endif

  always #5 clk = ~clk;

  var_lane_fifo_if #(.ElemWidth(EW), .NumLanes(NL), .FifoDepth(FD)) bus ();

  var_lane_fifo #(.ElemWidth(EW), .NumLanes(NL), .FifoDepth(FD)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .bus              (bus),
    .space_available_o(space),
    .elem_available_o (elem),
    .almost_full_o    (af),
    .almost_empty_o   (ae)
`ifdef VAR_LANE_FIFO_WATERMARK_EN
    ,
    .max_level_o      (maxl)
`endif
  );

  int checks = 0;
  int passes = 0;
  logic [EW-1:0] mq [$];
  int m_max = 0;

  // ---------------- reference model ----------------
  function automatic bit m_in_legal();
    int n = int'(bus.in_num_lanes_i);
    return (n >= 1) && (n <= NL);
  endfunction

  function automatic bit m_out_legal();
    int n = int'(bus.out_num_lanes_i);
    return (n >= 1) && (n <= NL);
  endfunction

  function automatic bit m_in_ready();
    return m_in_legal() && ((FD - mq.size()) >= int'(bus.in_num_lanes_i));
  endfunction

  function automatic bit m_out_valid();
    return m_out_legal() && (mq.size() >= int'(bus.out_num_lanes_i));
  endfunction

  function automatic logic [15:0] m_out_data();
    logic [15:0] r = '0;
    int n = int'(bus.out_num_lanes_i);
    int s = int'(bus.out_start_lane_i);
    if (!m_out_valid()) return r;
    for (int k = 0; k < n; k++) r[((s + k) % NL)*EW +: EW] = mq[k];
    return r;
  endfunction

  task automatic drive(input bit iv, input int in_n, input int in_s, input logic [15:0] din,
                       input bit ordy, input int on, input int os);
    bus.in_valid_i       = iv;
    bus.in_num_lanes_i   = 3'(in_n);
    bus.in_start_lane_i  = 2'(in_s);
    bus.in_data_i        = din;
    bus.out_ready_i      = ordy;
    bus.out_num_lanes_i  = 3'(on);
    bus.out_start_lane_i = 2'(os);
    #1;
  endtask

  // Advances one clock edge and applies the same transfer to the model.
  task automatic tick();
    bit pushf, popf, clr;
    int pn, is, on;
    logic [15:0] d;
    pushf = bus.in_valid_i && m_in_ready();
    popf  = bus.out_ready_i && m_out_valid();
    clr   = rst || flush;
    pn    = int'(bus.in_num_lanes_i);
    is    = int'(bus.in_start_lane_i);
    on    = int'(bus.out_num_lanes_i);
    d     = bus.in_data_i;
    @(posedge clk);
    if (clr) begin
      mq.delete();
      m_max = 0;
    end else begin
      if (popf) repeat (on) void'(mq.pop_front());
      if (pushf) for (int k = 0; k < pn; k++) mq.push_back(d[((is + k) % NL)*EW +: EW]);
      if (mq.size() > m_max) m_max = mq.size();
    end
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    drive(0, 2, 0, 16'h0, 0, 1, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (space !== 4'd8) $display("FAIL reset_space got %0d want 8", space); else passes++;
    checks++; if (elem !== 4'd0) $display("FAIL reset_elem got %0d want 0", elem); else passes++;
    checks++; if (bus.in_ready_o !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready_o); else passes++;
    checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid_o); else passes++;
    checks++; if (bus.out_data_o !== 16'h0) $display("FAIL reset_out_data got %h want 0000", bus.out_data_o); else passes++;
    checks++; if (ae !== 1'b1) $display("FAIL reset_almost_empty got %b want 1", ae); else passes++;
    checks++; if (af !== 1'b0) $display("FAIL reset_almost_full got %b want 0", af); else passes++;
  endtask

  task automatic test_wrap();
    drive(1, 2, 1, 16'hdcba, 0, 1, 0);
    tick();
    drive(1, 3, 3, 16'h89fe, 0, 1, 0);
    tick();
    checks++; if (elem !== 4'd5) $display("FAIL wrap_elem5 got %0d want 5", elem); else passes++;
    drive(0, 1, 0, 16'h0, 1, 4, 0);
    checks++; if (bus.out_valid_o !== 1'b1) $display("FAIL wrap_pop_valid got %b want 1", bus.out_valid_o); else passes++;
    checks++; if (bus.out_data_o !== 16'he8cb) $display("FAIL wrap_pop_data got %h want e8cb", bus.out_data_o); else passes++;
    tick();
    checks++; if (elem !== 4'd1) $display("FAIL wrap_elem1 got %0d want 1", elem); else passes++;
    drive(0, 1, 0, 16'h0, 1, 2, 2);
    checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL wrap_short_valid got %b want 0", bus.out_valid_o); else passes++;
    checks++; if (bus.out_data_o !== 16'h0) $display("FAIL wrap_short_data got %h want 0000", bus.out_data_o); else passes++;
    tick();
    checks++; if (elem !== 4'd1) $display("FAIL wrap_stall_elem got %0d want 1", elem); else passes++;
  endtask

  task automatic test_full();
    flush = 1'b1;
    drive(0, 1, 0, 16'h0, 0, 1, 0);
    tick();
    flush = 1'b0;
    drive(1, 4, 0, 16'h4321, 0, 1, 0);
    tick();
    tick();
    checks++; if (space !== 4'd0) $display("FAIL full_space got %0d want 0", space); else passes++;
    checks++; if (af !== 1'b1) $display("FAIL full_almost_full got %b want 1", af); else passes++;
    drive(1, 1, 2, 16'h4321, 1, 1, 3);
    checks++; if (bus.in_ready_o !== 1'b0) $display("FAIL full_in_ready got %b want 0", bus.in_ready_o); else passes++;
    checks++; if (bus.out_data_o !== 16'h1000) $display("FAIL full_pop_data got %h want 1000", bus.out_data_o); else passes++;
    tick();
    drive(0, 1, 0, 16'h0, 0, 1, 0);
    checks++; if (elem !== 4'd7) $display("FAIL full_elem7 got %0d want 7", elem); else passes++;
    checks++; if (bus.in_ready_o !== 1'b1) $display("FAIL full_ready_back got %b want 1", bus.in_ready_o); else passes++;
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp;
    flush = 1'b1;
    drive(0, 1, 0, 16'h0, 0, 1, 0);
    tick();
    flush = 1'b0;
    drive(1, 4, $urandom_range(0, 3), 16'($urandom), 0, 1, 0);
    tick();
    checks++; if (elem !== 4'd4) $display("FAIL simul_elem4 got %0d want 4", elem); else passes++;
    drive(1, 2, $urandom_range(0, 3), 16'($urandom), 1, 3, $urandom_range(0, 3));
    exp = m_out_data();
    checks++; if (bus.out_data_o !== exp) $display("FAIL simul_pop_data got %h want %h", bus.out_data_o, exp); else passes++;
    checks++; if (bus.in_ready_o !== 1'b1) $display("FAIL simul_in_ready got %b want 1", bus.in_ready_o); else passes++;
    tick();
    checks++; if (elem !== 4'd3) $display("FAIL simul_elem3 got %0d want 3", elem); else passes++;
    drive(0, 1, 0, 16'h0, 0, 3, 1);
    exp = m_out_data();
    checks++; if (bus.out_data_o !== exp) $display("FAIL simul_rest_data got %h want %h", bus.out_data_o, exp); else passes++;
  endtask

  task automatic test_flush_reset();
    drive(1, 3, 2, 16'h7a5c, 0, 1, 0);
    tick();
    checks++; if (elem !== 4'd6) $display("FAIL flush_elem6 got %0d want 6", elem); else passes++;
    flush = 1'b1;
    drive(1, 2, 0, 16'hffff, 0, 1, 0);
    tick();
    flush = 1'b0;
    drive(0, 1, 0, 16'h0, 0, 1, 0);
    checks++; if (elem !== 4'd0) $display("FAIL flush_elem got %0d want 0", elem); else passes++;
    checks++; if (space !== 4'd8) $display("FAIL flush_space got %0d want 8", space); else passes++;
    drive(1, 4, 1, 16'h2468, 0, 1, 0);
    tick();
    rst = 1'b1;
    drive(0, 1, 0, 16'h0, 1, 2, 0);
    tick();
    rst = 1'b0;
    drive(0, 1, 0, 16'h0, 0, 2, 0);
    checks++; if (elem !== 4'd0) $display("FAIL rst_pop_elem got %0d want 0", elem); else passes++;
    checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL rst_pop_valid got %b want 0", bus.out_valid_o); else passes++;
    checks++; if (bus.out_data_o !== 16'h0) $display("FAIL rst_pop_data got %h want 0000", bus.out_data_o); else passes++;
  endtask

  task automatic test_random();
    logic [15:0] exp;
    for (int i = 0; i < 400; i++) begin
      flush = ($urandom_range(0, 40) == 0);
      drive($urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 3), 16'($urandom),
            $urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 3));
      exp = m_out_data();
      checks++; if (bus.in_req_valid_o !== m_in_legal()) $display("FAIL rnd_in_req got %b want %b", bus.in_req_valid_o, m_in_legal()); else passes++;
      checks++; if (bus.out_req_valid_o !== m_out_legal()) $display("FAIL rnd_out_req got %b want %b", bus.out_req_valid_o, m_out_legal()); else passes++;
      checks++; if (bus.in_ready_o !== m_in_ready()) $display("FAIL rnd_in_ready got %b want %b", bus.in_ready_o, m_in_ready()); else passes++;
      checks++; if (bus.out_valid_o !== m_out_valid()) $display("FAIL rnd_out_valid got %b want %b", bus.out_valid_o, m_out_valid()); else passes++;
      checks++; if (bus.out_data_o !== exp) $display("FAIL rnd_out_data got %h want %h", bus.out_data_o, exp); else passes++;
      checks++; if (int'(elem) != mq.size()) $display("FAIL rnd_elem got %0d want %0d", elem, mq.size()); else passes++;
      checks++; if (int'(space) != FD - mq.size()) $display("FAIL rnd_space got %0d want %0d", space, FD - mq.size()); else passes++;
      checks++; if (af !== (mq.size() >= FD - NL)) $display("FAIL rnd_almost_full got %b want %b", af, mq.size() >= FD - NL); else passes++;
      checks++; if (ae !== (mq.size() <= NL)) $display("FAIL rnd_almost_empty got %b want %b", ae, mq.size() <= NL); else passes++;
`ifdef VAR_LANE_FIFO_WATERMARK_EN
      checks++; if (int'(maxl) != m_max) $display("FAIL rnd_max_level got %0d want %0d", maxl, m_max); else passes++;
`endif
      tick();
    end
    flush = 1'b0;
  endtask

`ifdef VAR_LANE_FIFO_WATERMARK_EN
  task automatic test_watermark();
    flush = 1'b1;
    drive(0, 1, 0, 16'h0, 0, 1, 0);
    tick();
    flush = 1'b0;
    drive(1, 4, 0, 16'h1357, 0, 1, 0);
    tick();
    drive(1, 3, 2, 16'h9bdf, 0, 1, 0);
    tick();
    drive(0, 1, 0, 16'h0, 1, 4, 0);
    tick();
    drive(0, 1, 0, 16'h0, 1, 1, 0);
    tick();
    drive(0, 1, 0, 16'h0, 0, 1, 0);
    checks++; if (maxl !== 4'd7) $display("FAIL wm_peak got %0d want 7", maxl); else passes++;
    checks++; if (elem !== 4'd2) $display("FAIL wm_elem got %0d want 2", elem); else passes++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checks++; if (maxl !== 4'd0) $display("FAIL wm_flush got %0d want 0", maxl); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_full();
    test_simultaneous();
    test_flush_reset();
`ifdef VAR_LANE_FIFO_WATERMARK_EN
    test_watermark();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
